// File: rtl/eq_div_scheduler_if.sv
// Request, divider and result bundle shared by the scheduler and its environment.
// Index convention used throughout: path I and path Q carry identical signal sets.
interface eq_div_scheduler_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned QW = 64
);
    logic          req_i_val;
    logic          req_i_rdy;
    logic [DW-1:0] req_i_dividend;
    logic [DW-1:0] req_i_divisor;
    logic          req_q_val;
    logic          req_q_rdy;
    logic [DW-1:0] req_q_dividend;
    logic [DW-1:0] req_q_divisor;

    logic          div_val;
    logic [DW-1:0] div_dividend;
    logic [DW-1:0] div_divisor;
    logic          div_oval;
    logic [QW-1:0] div_odata;

    logic          res_i_val;
    logic          res_i_rdy;
    logic [QW-1:0] res_i_data;
    logic          res_q_val;
    logic          res_q_rdy;
    logic [QW-1:0] res_q_data;

    // Environment side: requesters, divider core and result consumers
    modport master (
        output req_i_val, req_i_dividend, req_i_divisor,
        output req_q_val, req_q_dividend, req_q_divisor,
        input  req_i_rdy, req_q_rdy,
        input  div_val, div_dividend, div_divisor,
        output div_oval, div_odata,
        input  res_i_val, res_i_data, res_q_val, res_q_data,
        output res_i_rdy, res_q_rdy
    );

    // Scheduler side
    modport slave (
        input  req_i_val, req_i_dividend, req_i_divisor,
        input  req_q_val, req_q_dividend, req_q_divisor,
        output req_i_rdy, req_q_rdy,
        output div_val, div_dividend, div_divisor,
        input  div_oval, div_odata,
        output res_i_val, res_i_data, res_q_val, res_q_data,
        input  res_i_rdy, res_q_rdy
    );
endinterface

// File: rtl/eq_div_scheduler.sv
// Shares one fixed-latency pipelined divider between the equalizer I and Q coefficient paths.
// Round-robin grant, tag pipeline aligned with the divider latency, and per-path FWFT result
// FIFOs. Issue is credit-gated so a returning result always has a FIFO slot waiting for it.
// Path index 0 is I, index 1 is Q.
module eq_div_scheduler #(
    parameter int unsigned DW          = 32,
    parameter int unsigned QW          = 64,
    parameter int unsigned DIV_LATENCY = 10,
    parameter int unsigned OUT_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    eq_div_scheduler_if.slave bus,
    output logic              err_sync,
    output logic              busy
);
    localparam int unsigned AW = $clog2(OUT_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TL = DIV_LATENCY + 1;
    localparam int unsigned BW = $clog2(TL + 1);

    logic [1:0]    req_val;
    logic [1:0]    res_rdy;
    logic [1:0]    elig;
    logic [1:0]    grant;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    ret;

    logic [CW-1:0] credit_q [2];
    logic [CW-1:0] credit_d [2];
    logic [CW-1:0] cnt_q    [2];
    logic [CW-1:0] cnt_d    [2];
    logic [AW-1:0] rptr_q   [2];
    logic [AW-1:0] wptr_q   [2];
    logic [QW-1:0] fifo_mem [2][OUT_DEPTH];

    logic          last_was_q;
    logic          div_val_q;
    logic [DW-1:0] dividend_q;
    logic [DW-1:0] divisor_q;
    logic [TL-1:0] tag_vld_q;
    logic [TL-1:0] tag_path_q;
    logic [BW-1:0] blank_q;
    logic          err_q;

    logic          blank;
    logic          tag_vld;
    logic          tag_path;
    logic          oval_eff;
    logic          hit;
    logic          miss_tag;

    // Round-robin arbitration over credit-eligible requests
    always_comb begin
        req_val  = {bus.req_q_val, bus.req_i_val};
        res_rdy  = {bus.res_q_rdy, bus.res_i_rdy};
        elig[0]  = req_val[0] && (credit_q[0] != '0);
        elig[1]  = req_val[1] && (credit_q[1] != '0);
        grant[0] = elig[0] && (!elig[1] || last_was_q);
        grant[1] = elig[1] && (!elig[0] || !last_was_q);
    end

    // Return side: match the due tag against div_oval, derive pushes, pops and credit returns
    always_comb begin
        blank    = (blank_q != '0);
        tag_vld  = tag_vld_q[TL-1];
        tag_path = tag_path_q[TL-1];
        // Results arriving in the post-reset window belong to ops from before reset
        oval_eff = bus.div_oval && !blank;
        hit      = tag_vld && oval_eff;
        miss_tag = tag_vld && !oval_eff;
        push     = {hit && tag_path, hit && !tag_path};
        ret      = {miss_tag && tag_path, miss_tag && !tag_path};
        pop      = '0;
        for (int p = 0; p < 2; p++) begin
            pop[p]      = res_rdy[p] && (cnt_q[p] != '0);
            credit_d[p] = credit_q[p] + CW'(pop[p]) + CW'(ret[p]) - CW'(grant[p]);
            cnt_d[p]    = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
        end
    end

    // Issue register toward the divider plus the round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_val_q  <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            last_was_q <= 1'b1;
        end else begin
            div_val_q <= |grant;
            if (grant[0]) begin
                dividend_q <= bus.req_i_dividend;
                divisor_q  <= bus.req_i_divisor;
                last_was_q <= 1'b0;
            end else if (grant[1]) begin
                dividend_q <= bus.req_q_dividend;
                divisor_q  <= bus.req_q_divisor;
                last_was_q <= 1'b1;
            end
        end
    end

    // Tag pipeline: last stage lines up with the div_oval of the op it describes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q  <= '0;
            tag_path_q <= '0;
        end else begin
            tag_vld_q  <= {tag_vld_q[TL-2:0], |grant};
            tag_path_q <= {tag_path_q[TL-2:0], grant[1]};
        end
    end

    // Post-reset blanking counter and sticky sync error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= BW'(TL);
            err_q   <= 1'b0;
        end else begin
            if (blank) begin
                blank_q <= blank_q - BW'(1);
            end
            if (!blank && (tag_vld != oval_eff)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Credits, FIFO occupancy and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                credit_q[p] <= CW'(OUT_DEPTH);
                cnt_q[p]    <= '0;
                rptr_q[p]   <= '0;
                wptr_q[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                credit_q[p] <= credit_d[p];
                cnt_q[p]    <= cnt_d[p];
                if (push[p]) begin
                    wptr_q[p] <= wptr_q[p] + AW'(1);
                end
                if (pop[p]) begin
                    rptr_q[p] <= rptr_q[p] + AW'(1);
                end
            end
        end
    end

    // FIFO storage, no reset needed: occupancy gates visibility
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                fifo_mem[p][wptr_q[p]] <= bus.div_odata;
            end
        end
    end

    // Output drive
    always_comb begin
        bus.req_i_rdy    = grant[0];
        bus.req_q_rdy    = grant[1];
        bus.div_val      = div_val_q;
        bus.div_dividend = dividend_q;
        bus.div_divisor  = divisor_q;
        bus.res_i_val    = (cnt_q[0] != '0);
        bus.res_q_val    = (cnt_q[1] != '0);
        bus.res_i_data   = (cnt_q[0] != '0) ? fifo_mem[0][rptr_q[0]] : '0;
        bus.res_q_data   = (cnt_q[1] != '0) ? fifo_mem[1][rptr_q[1]] : '0;
        err_sync         = err_q;
        busy             = (|tag_vld_q) || (cnt_q[0] != '0) || (cnt_q[1] != '0);
    end
endmodule

// File: tb/tb_eq_div_scheduler.sv
// Directed bench for eq_div_scheduler with a behavioural fixed-latency divider.
module tb_eq_div_scheduler;
    localparam int unsigned DW    = 32;
    localparam int unsigned QW    = 64;
    localparam int unsigned LAT   = 10;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_sync;
    logic busy;
    logic force_oval = 1'b0;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int first_i_cyc = -1;
    bit arm_lat = 1'b0;

    logic [63:0] exp_i [$];
    logic [63:0] exp_q [$];

    eq_div_scheduler_if #(.DW(DW), .QW(QW)) bus ();

    eq_div_scheduler #(
        .DW(DW), .QW(QW), .DIV_LATENCY(LAT), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .err_sync(err_sync), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider core model: quotient in [63:32], remainder in [24:0], not affected by rst_n
    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b);
        int q;
        int r;
        if (b == 32'd0) return 64'd0;
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {q[31:0], 7'd0, r[24:0]};
    endfunction

    logic [LAT-1:0]       pv = '0;
    logic [LAT-1:0][63:0] pd = '0;
    always @(posedge clk) begin
        pv <= {pv[LAT-2:0], bus.div_val};
        pd <= {pd[LAT-2:0], div_model(bus.div_dividend, bus.div_divisor)};
    end
    assign bus.div_oval  = pv[LAT-1] | force_oval;
    assign bus.div_odata = pd[LAT-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer monitor: every pop must deliver the next expected result of that path
    always @(negedge clk) begin
        #2;
        if (arm_lat && first_i_cyc < 0 && bus.res_i_val) first_i_cyc = cyc;
        if (rst_n && bus.res_i_val && bus.res_i_rdy) begin
            if (exp_i.size() == 0) check_eq("res_i_extra_pop", 64'(exp_i.size()), 64'd1);
            else check_eq("res_i_data", bus.res_i_data, exp_i.pop_front());
        end
        if (rst_n && bus.res_q_val && bus.res_q_rdy) begin
            if (exp_q.size() == 0) check_eq("res_q_extra_pop", 64'(exp_q.size()), 64'd1);
            else check_eq("res_q_data", bus.res_q_data, exp_q.pop_front());
        end
    end

    // One cycle of requests; called just after a negedge, returns at the next negedge
    task automatic step(input bit vi, input logic [31:0] ddi, input logic [31:0] dvi, input int qi,
                        input bit vq, input logic [31:0] ddq, input logic [31:0] dvq, input int qq,
                        output bit gi, output bit gq);
        bus.req_i_val      = vi;
        bus.req_i_dividend = ddi;
        bus.req_i_divisor  = dvi;
        bus.req_q_val      = vq;
        bus.req_q_dividend = ddq;
        bus.req_q_divisor  = dvq;
        #1;
        gi = bus.req_i_rdy;
        gq = bus.req_q_rdy;
        if (gi) exp_i.push_back({qi, 32'h0});
        if (gq) exp_q.push_back({qq, 32'h0});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit gi;
        bit gq;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, gi, gq);
    endtask

    task automatic wait_idle(input string tag);
        bit gi;
        bit gq;
        int n = 0;
        while (busy && n < 200) begin
            step(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, gi, gq);
            n++;
        end
        check_eq(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        bit gi;
        bit gq;
        int ki;
        int kq;
        int ng;
        int seq;
        int first_g;
        int gc;
        logic [15:0] gseq;

        bus.req_i_val = 1'b0; bus.req_i_dividend = '0; bus.req_i_divisor = '0;
        bus.req_q_val = 1'b0; bus.req_q_dividend = '0; bus.req_q_divisor = '0;
        bus.res_i_rdy = 1'b0; bus.res_q_rdy = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_res_i_val", 64'(bus.res_i_val), 64'd0);
        check_eq("rst_res_q_val", 64'(bus.res_q_val), 64'd0);
        check_eq("rst_div_val", 64'(bus.div_val), 64'd0);
        check_eq("rst_err_sync", 64'(err_sync), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_res_i_data", bus.res_i_data, 64'd0);
        rst_n = 1'b1;
        idle(LAT + 2);

        // Both paths, 8 ops each, consumers ready: strict I,Q alternation
        bus.res_i_rdy = 1'b1; bus.res_q_rdy = 1'b1;
        ki = 0; kq = 0; gseq = '0; first_g = -1; arm_lat = 1'b1;
        for (int c = 0; c < 16; c++) begin
            gc = cyc;
            step(ki < 8, 32'(10240 * (ki + 1)), 32'd10, 1024 * (ki + 1),
                 kq < 8, 32'(-1024 * (kq + 1)), 32'd1, -1024 * (kq + 1), gi, gq);
            gseq[c] = gq;
            if (gi && first_g < 0) first_g = gc;
            if (gi) ki++;
            if (gq) kq++;
        end
        check_eq("rr_order", 64'(gseq), 64'h0000_0000_0000_AAAA);
        check_eq("i_grants", 64'(ki), 64'd8);
        check_eq("q_grants", 64'(kq), 64'd8);
        wait_idle("drain_burst");
        arm_lat = 1'b0;
        check_eq("first_res_latency", 64'(first_i_cyc - first_g), 64'(2 + LAT));
        check_eq("burst_i_all_returned", 64'(exp_i.size()), 64'd0);
        check_eq("burst_q_all_returned", 64'(exp_q.size()), 64'd0);
        check_eq("burst_err_sync", 64'(err_sync), 64'd0);

        // Credit limit: I requests continuously, consumer stalled
        bus.res_i_rdy = 1'b0; bus.res_q_rdy = 1'b0;
        seq = 0; ng = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 32'(seq), 32'd1, seq, 1'b0, 0, 0, 0, gi, gq);
            if (gi) begin ng++; seq++; end
        end
        check_eq("credit_grants", 64'(ng), 64'd16);
        check_eq("credit_block_rdy", 64'(bus.req_i_rdy), 64'd0);
        check_eq("full_res_i_val", 64'(bus.res_i_val), 64'd1);
        bus.res_i_rdy = 1'b1;
        step(1'b1, 32'(seq), 32'd1, seq, 1'b0, 0, 0, 0, gi, gq);
        check_eq("no_grant_in_pop_cycle", 64'(gi), 64'd0);
        bus.res_i_rdy = 1'b0;
        ng = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 32'(seq), 32'd1, seq, 1'b0, 0, 0, 0, gi, gq);
            if (gi) begin ng++; seq++; end
        end
        check_eq("one_pop_one_grant", 64'(ng), 64'd1);

        // Pop from a full FIFO while new results stream in: order must be kept
        bus.res_i_rdy = 1'b1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 8; c++) begin
            step(1'b1, 32'(seq), 32'd1, seq, 1'b0, 0, 0, 0, gi, gq);
            if (gi) begin ng++; seq++; end
        end
        check_eq("refill_grants", 64'(ng), 64'd8);
        wait_idle("drain_refill");
        check_eq("refill_all_returned", 64'(exp_i.size()), 64'd0);

        // Known quotients through the divider model
        bus.res_i_rdy = 1'b0; bus.res_q_rdy = 1'b0;
        ki = 0; kq = 0;
        for (int c = 0; c < 4; c++) begin
            step(ki == 0, 32'd1024000, 32'd250, 4096, kq == 0, 32'hFFFF_EC00, 32'd1, -5120, gi, gq);
            if (gi) ki++;
            if (gq) kq++;
        end
        idle(LAT + 4);
        check_eq("quot_i_4096", 64'(bus.res_i_data[63:32]), 64'd4096);
        check_eq("quot_q_m5120", 64'(bus.res_q_data[63:32]), 64'h0000_0000_FFFF_EC00);

        // Spurious div_oval with no tag in flight
        force_oval = 1'b1;
        idle(1);
        force_oval = 1'b0;
        check_eq("err_set", 64'(err_sync), 64'd1);
        idle(3);
        check_eq("err_sticky", 64'(err_sync), 64'd1);
        check_eq("err_occ_i", 64'(bus.res_i_val), 64'd1);
        check_eq("err_occ_q", 64'(bus.res_q_val), 64'd1);
        bus.res_i_rdy = 1'b1; bus.res_q_rdy = 1'b1;
        idle(1);
        check_eq("err_no_push_i", 64'(bus.res_i_val), 64'd0);
        check_eq("err_no_push_q", 64'(bus.res_q_val), 64'd0);

        // Reset with ops in flight
        ng = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 32'd77, 32'd7, 11, 1'b1, 32'd99, 32'd9, 11, gi, gq);
            ng += int'(gi) + int'(gq);
        end
        check_eq("inflight_before_reset", 64'(ng), 64'd5);
        rst_n = 1'b0;
        exp_i.delete();
        exp_q.delete();
        bus.req_i_val = 1'b0; bus.req_q_val = 1'b0;
        #1;
        check_eq("mid_rst_res_i_val", 64'(bus.res_i_val), 64'd0);
        check_eq("mid_rst_res_q_val", 64'(bus.res_q_val), 64'd0);
        check_eq("mid_rst_div_val", 64'(bus.div_val), 64'd0);
        check_eq("mid_rst_err_sync", 64'(err_sync), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(LAT + 3);
        check_eq("stale_err_sync", 64'(err_sync), 64'd0);
        check_eq("stale_busy", 64'(busy), 64'd0);
        bus.res_i_rdy = 1'b0; bus.res_q_rdy = 1'b0;
        seq = 100; ng = 0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 32'(seq), 32'd1, seq, 1'b0, 0, 0, 0, gi, gq);
            if (gi) begin ng++; seq++; end
        end
        check_eq("credits_after_reset", 64'(ng), 64'd16);
        bus.res_i_rdy = 1'b1; bus.res_q_rdy = 1'b1;
        wait_idle("drain_after_reset");
        check_eq("final_i_returned", 64'(exp_i.size()), 64'd0);
        check_eq("final_err_sync", 64'(err_sync), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
